// File: rtl/mmc3_scanline_irq.sv
// mmc3_scanline_irq
//   Scanline IRQ stage of the MMC3/MMC6 mapper family. PPU A12 rising edges
//   are qualified against the number of CPU M2 falling edges seen while A12
//   was low. They then clock an 8-bit reload/decrement counter. The IRQ is
//   raised when that counter reaches zero and the IRQ is enabled.
//
//   reg_addr encoding ({cpu.addr[15:13], cpu.addr[0]}):
//     4'hC = $C000 latch, 4'hD = $C001 reload,
//     4'hE = $E000 irq disable/ack, 4'hF = $E001 irq enable
//
//   Parameters
//     FILT_M2      M2 falling edges A12 must stay low before a rise counts (1..7)
//     SYNC_STAGES  synchroniser depth for ppu_a12 and cpu_m2 (>=2)
//
//   Ports
//     clk, map_rst          system clock, synchronous active-high reset
//     decode_en             CPU write window (level, may span several clk)
//     reg_addr, cpu_data    register select and write data
//     cpu_m2, ppu_a12       asynchronous inputs, synchronised internally
//     mmc3a                 1 = rev-A counter semantics, 0 = rev-B/MMC6
//     irq                   registered IRQ request, active-high
//     sst_*                 save-state access; live only with MMC3_IRQ_SST_EN
//
//   Build option: define MMC3_IRQ_SST_EN to map latch/counter/flags/irq onto
//   save-state indices 16..19. Without it sst_ce=0 and sst_do=8'hFF.
module mmc3_scanline_irq #(
    parameter int FILT_M2     = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       map_rst,
    input  logic       decode_en,
    input  logic [3:0] reg_addr,
    input  logic [7:0] cpu_data,
    input  logic       cpu_m2,
    input  logic       ppu_a12,
    input  logic       mmc3a,
    output logic       irq,
    input  logic       sst_act,
    input  logic       sst_we,
    input  logic [7:0] sst_addr,
    input  logic [7:0] sst_dati,
    output logic       sst_ce,
    output logic [7:0] sst_do
);

    localparam logic [2:0] FILT = 3'(FILT_M2);

    logic [SYNC_STAGES-1:0] a12_sync;
    logic [SYNC_STAGES-1:0] m2_sync;
    logic                   a12_s, a12_s_d;
    logic                   m2_s, m2_s_d;
    logic                   m2_fall;
    logic [2:0]             low_cnt;
    logic                   clk_ev;

    logic [7:0] latch, counter;
    logic       reload, irq_en;

    logic [7:0] latch_nxt, counter_nxt;
    logic       reload_nxt, irq_en_nxt, irq_nxt;
    logic       ev, wr, en_eff, fire;

    assign a12_s   = a12_sync[SYNC_STAGES-1];
    assign m2_s    = m2_sync[SYNC_STAGES-1];
    assign m2_fall = m2_s_d & ~m2_s;
    assign clk_ev  = a12_s & ~a12_s_d & (low_cnt == FILT);

    // The save-state engine freezes the CPU-visible side; the filter keeps
    // tracking so it resumes in step with the PPU.
    assign ev = clk_ev & ~sst_act;
    assign wr = decode_en & ~sst_act;

    // Synchronisers and A12 low-time filter.
    always_ff @(posedge clk) begin
        if (map_rst) begin
            a12_sync <= '0;
            m2_sync  <= '0;
            a12_s_d  <= 1'b0;
            m2_s_d   <= 1'b0;
            low_cnt  <= 3'd0;
        end else begin
            a12_sync <= {a12_sync[SYNC_STAGES-2:0], ppu_a12};
            m2_sync  <= {m2_sync[SYNC_STAGES-2:0], cpu_m2};
            a12_s_d  <= a12_s;
            m2_s_d   <= m2_s;
            if (a12_s)
                low_cnt <= 3'd0;
            else if (m2_fall && low_cnt != FILT)
                low_cnt <= low_cnt + 3'd1;
        end
    end

    // Ordering within one edge: an $E001 write enables the event it coincides
    // with; the event then runs on the old latch/reload; afterwards $C000,
    // $C001 and $E000 writes land on top (so $E000 beats a same-edge fire).
    always_comb begin
        latch_nxt   = latch;
        counter_nxt = counter;
        reload_nxt  = reload;
        irq_en_nxt  = irq_en;
        irq_nxt     = irq;
        fire        = 1'b0;
        en_eff      = irq_en | (wr & (reg_addr == 4'hF));

        if (ev) begin
            counter_nxt = (counter == 8'd0 || reload) ? latch : counter - 8'd1;
            reload_nxt  = 1'b0;
            // Rev-A does not fire when a zero counter reloads zero on its own.
            fire = (counter_nxt == 8'd0) & en_eff &
                   (~mmc3a | (counter != 8'd0) | reload);
            if (fire)
                irq_nxt = 1'b1;
        end

        if (wr) begin
            case (reg_addr)
                4'hC: latch_nxt = cpu_data;
                4'hD: reload_nxt = 1'b1;
                4'hE: begin
                    irq_en_nxt = 1'b0;
                    irq_nxt    = 1'b0;
                end
                4'hF: irq_en_nxt = 1'b1;
                default: ;
            endcase
        end

`ifdef MMC3_IRQ_SST_EN
        // sst_act already blocks ev/wr, so these never collide with them.
        if (sst_act && sst_we && sst_ce) begin
            case (sst_addr[1:0])
                2'd0: latch_nxt   = sst_dati;
                2'd1: counter_nxt = sst_dati;
                2'd2: begin
                    reload_nxt = sst_dati[1];
                    irq_en_nxt = sst_dati[0];
                end
                default: irq_nxt = sst_dati[0];
            endcase
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (map_rst) begin
            latch   <= 8'd0;
            counter <= 8'd0;
            reload  <= 1'b0;
            irq_en  <= 1'b0;
            irq     <= 1'b0;
        end else begin
            latch   <= latch_nxt;
            counter <= counter_nxt;
            reload  <= reload_nxt;
            irq_en  <= irq_en_nxt;
            irq     <= irq_nxt;
        end
    end

`ifdef MMC3_IRQ_SST_EN
    assign sst_ce = (sst_addr[7:2] == 6'd4);
    always_comb begin
        case (sst_addr[1:0])
            2'd0:    sst_do = latch;
            2'd1:    sst_do = counter;
            2'd2:    sst_do = {6'd0, reload, irq_en};
            default: sst_do = {7'd0, irq};
        endcase
    end
`else
    assign sst_ce = 1'b0;
    assign sst_do = 8'hFF;
    logic unused_sst;
    assign unused_sst = &{1'b0, sst_we, sst_addr, sst_dati};
`endif

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
module tb_mmc3_scanline_irq;

    localparam int FILT_M2     = 3;
    localparam int SYNC_STAGES = 2;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       map_rst = 1'b1;
    logic       decode_en = 1'b0;
    logic [3:0] reg_addr = 4'h0;
    logic [7:0] cpu_data = 8'h00;
    logic       cpu_m2 = 1'b0;
    logic       ppu_a12 = 1'b0;
    logic       mmc3a = 1'b0;
    logic       irq;
    logic       sst_act = 1'b0;
    logic       sst_we = 1'b0;
    logic [7:0] sst_addr = 8'h00;
    logic [7:0] sst_dati = 8'h00;
    logic       sst_ce;
    logic [7:0] sst_do;

    always #5 clk = ~clk;

    mmc3_scanline_irq #(.FILT_M2(FILT_M2), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .map_rst(map_rst), .decode_en(decode_en),
        .reg_addr(reg_addr), .cpu_data(cpu_data), .cpu_m2(cpu_m2),
        .ppu_a12(ppu_a12), .mmc3a(mmc3a), .irq(irq),
        .sst_act(sst_act), .sst_we(sst_we), .sst_addr(sst_addr),
        .sst_dati(sst_dati), .sst_ce(sst_ce), .sst_do(sst_do)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // Architectural registers plus the number of M2 falls seen since A12 last
    // went low (or since reset). A rise counts when that number reached FILT_M2.
    logic [7:0] m_latch, m_counter;
    logic       m_reload, m_irq_en, m_irq;
    int         m_falls;

    function automatic void model_reset();
        m_latch = 8'd0; m_counter = 8'd0; m_reload = 1'b0;
        m_irq_en = 1'b0; m_irq = 1'b0; m_falls = 0;
    endfunction

    // One clock edge carrying an optional counter event and an optional write.
    function automatic void model_step(bit ev, bit wr, logic [3:0] a, logic [7:0] d);
        int old_cnt, new_cnt;
        if (wr && a == 4'hF) m_irq_en = 1'b1;
        if (ev) begin
            old_cnt = int'(m_counter);
            if (old_cnt == 0 || m_reload) new_cnt = int'(m_latch);
            else                          new_cnt = old_cnt - 1;
            if (new_cnt == 0 && m_irq_en && (!mmc3a || old_cnt != 0 || m_reload))
                m_irq = 1'b1;
            m_counter = 8'(new_cnt);
            m_reload  = 1'b0;
        end
        if (wr) begin
            if (a == 4'hC) m_latch = d;
            if (a == 4'hD) m_reload = 1'b1;
            if (a == 4'hE) begin m_irq_en = 1'b0; m_irq = 1'b0; end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        map_rst = 1'b1;
        tick(2);
        map_rst = 1'b0;
        model_reset();
        tick(1);
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
        reg_addr = a; cpu_data = d; decode_en = 1'b1;
        tick($urandom_range(1, 3));
        decode_en = 1'b0;
        model_step(1'b0, !sst_act, a, d);
        n_vec++;
        if (irq !== m_irq) begin
            n_err++;
            $display("FAIL write_%h: irq=%b expected %b", a, irq, m_irq);
        end
        tick(1);
    endtask

    task automatic m2_pulses(input int n);
        repeat (n) begin
            cpu_m2 = 1'b1; tick(2);
            cpu_m2 = 1'b0; tick(2);
        end
        m_falls += n;
    endtask

    // A12 low period with nf M2 falls, then a rise. Optionally a write is
    // placed exactly on the edge where the rise is counted.
    task automatic a12_rise(input int nf, input bit do_wr,
                            input logic [3:0] a, input logic [7:0] d);
        logic pre_irq;
        bit   ev;
        m2_pulses(nf);
        tick(SYNC_STAGES + 2);
        pre_irq = m_irq;
        ppu_a12 = 1'b1;
        tick(SYNC_STAGES);
        n_vec++;
        if (irq !== pre_irq) begin
            n_err++;
            $display("FAIL pre_rise: irq=%b expected %b", irq, pre_irq);
        end
        if (do_wr) begin reg_addr = a; cpu_data = d; decode_en = 1'b1; end
        tick(1);
        decode_en = 1'b0;
        ev = (m_falls >= FILT_M2) && !sst_act;
        model_step(ev, do_wr && !sst_act, a, d);
        m_falls = 0;
        n_vec++;
        if (irq !== m_irq) begin
            n_err++;
            $display("FAIL post_rise: irq=%b expected %b (falls=%0d wr=%b a=%h)",
                     irq, m_irq, nf, do_wr, a);
        end
        tick(2);
        ppu_a12 = 1'b0;
        tick(SYNC_STAGES + 3);
    endtask

    task automatic rise(input int nf);
        a12_rise(nf, 1'b0, 4'h0, 8'h00);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        sst_addr = 8'h00;
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: irq=%b expected 0", irq); end
        n_vec++;
        if (sst_ce !== 1'b0) begin n_err++; $display("FAIL reset_sst_ce: %b expected 0", sst_ce); end
`ifndef MMC3_IRQ_SST_EN
        sst_addr = 8'd16;
        tick(1);
        n_vec++;
        if (sst_ce !== 1'b0 || sst_do !== 8'hFF) begin
            n_err++;
            $display("FAIL sst_off: ce=%b do=%h expected 0/ff", sst_ce, sst_do);
        end
        sst_addr = 8'h00;
`endif
    endtask

    task automatic test_count_down();
        do_reset();
        mmc3a = 1'b0;
        cpu_write(4'hC, 8'd5);
        cpu_write(4'hD, 8'd0);
        cpu_write(4'hF, 8'd0);
        for (int i = 0; i < 8; i++) rise(FILT_M2 + (i % 2));
    endtask

    task automatic test_short_low();
        do_reset();
        mmc3a = 1'b0;
        cpu_write(4'hC, 8'd0);
        cpu_write(4'hF, 8'd0);
        for (int i = 0; i < 20; i++) rise(FILT_M2 - 1);
        rise(FILT_M2);
    endtask

    task automatic test_latch_zero_rev_b();
        do_reset();
        mmc3a = 1'b0;
        cpu_write(4'hC, 8'd0);
        cpu_write(4'hF, 8'd0);
        for (int i = 0; i < 3; i++) begin
            rise(FILT_M2);
            rise(FILT_M2 + 2);
            cpu_write(4'hE, 8'd0);
        end
    endtask

    task automatic test_rev_a();
        do_reset();
        mmc3a = 1'b1;
        cpu_write(4'hC, 8'd0);
        cpu_write(4'hF, 8'd0);
        for (int i = 0; i < 3; i++) rise(FILT_M2);
        cpu_write(4'hD, 8'd0);
        rise(FILT_M2);
        mmc3a = 1'b0;
    endtask

    task automatic test_e_at_zero();
        do_reset();
        cpu_write(4'hC, 8'd1);
        cpu_write(4'hD, 8'd0);
        cpu_write(4'hF, 8'd0);
        rise(FILT_M2);                        // reload -> 1
        a12_rise(FILT_M2, 1'b1, 4'hE, 8'd0);  // 1 -> 0 with $E000 on the same edge
        rise(FILT_M2);
        rise(FILT_M2);
    endtask

    task automatic test_simultaneous();
        do_reset();
        cpu_write(4'hC, 8'd2);
        cpu_write(4'hD, 8'd0);
        a12_rise(FILT_M2, 1'b1, 4'hC, 8'd0);  // loads old latch 2, latch becomes 0
        rise(FILT_M2);                        // 2 -> 1
        a12_rise(FILT_M2, 1'b1, 4'hF, 8'd0);  // 1 -> 0, enable applies now
        cpu_write(4'hE, 8'd0);
        cpu_write(4'hC, 8'd1);
        cpu_write(4'hF, 8'd0);
        a12_rise(FILT_M2, 1'b1, 4'hD, 8'd0);  // 0 reloads 1, reload ends set
        rise(FILT_M2);                        // reload -> 1 again, no irq
        rise(FILT_M2);                        // 1 -> 0, irq
    endtask

    task automatic test_sst_act();
        do_reset();
        cpu_write(4'hC, 8'd0);
        cpu_write(4'hF, 8'd0);
        sst_act = 1'b1;
        rise(FILT_M2);                        // suspended: no event
        cpu_write(4'hE, 8'd0);                // suspended: ignored
        sst_act = 1'b0;
        rise(FILT_M2);
    endtask

    task automatic test_mid_filter_reset();
        do_reset();
        m2_pulses(FILT_M2 - 1);
        tick(SYNC_STAGES + 2);
        do_reset();
        cpu_write(4'hC, 8'd0);
        cpu_write(4'hF, 8'd0);
        rise(1);
        rise(FILT_M2);
    endtask

    task automatic test_random();
        int op;
        logic [3:0] a;
        do_reset();
        for (int i = 0; i < 180; i++) begin
            op = $urandom_range(0, 9);
            a  = 4'hC + 4'($urandom_range(0, 3));
            if (op < 3)
                cpu_write(a, 8'($urandom_range(0, 3)));
            else if (op < 9)
                a12_rise($urandom_range(0, 5), ($urandom_range(0, 3) == 0),
                         a, 8'($urandom_range(0, 3)));
            else
                mmc3a = ~mmc3a;
        end
        mmc3a = 1'b0;
    endtask

`ifdef MMC3_IRQ_SST_EN
    task automatic sst_check(input logic [7:0] idx, input logic [7:0] exp);
        sst_addr = idx;
        #1;
        n_vec++;
        if (sst_ce !== 1'b1 || sst_do !== exp) begin
            n_err++;
            $display("FAIL sst_read_%0d: ce=%b do=%h expected 1/%h", idx, sst_ce, sst_do, exp);
        end
    endtask

    task automatic sst_write(input logic [7:0] idx, input logic [7:0] d);
        sst_addr = idx; sst_dati = d; sst_we = 1'b1;
        tick(1);
        sst_we = 1'b0;
    endtask

    task automatic test_sst();
        do_reset();
        sst_act = 1'b1;
        sst_write(8'd16, 8'h20);
        sst_write(8'd17, 8'h07);
        sst_write(8'd18, 8'h03);
        m_latch = 8'h20; m_counter = 8'h07; m_reload = 1'b1; m_irq_en = 1'b1;
        sst_check(8'd16, 8'h20);
        sst_check(8'd17, 8'h07);
        sst_check(8'd18, 8'h03);
        sst_check(8'd19, {7'd0, m_irq});
        sst_act = 1'b0;
        rise(FILT_M2);
        sst_check(8'd17, 8'h20);
        sst_check(8'd18, {6'd0, m_reload, m_irq_en});
        sst_addr = 8'h00;
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_count_down();
        test_short_low();
        test_latch_zero_rev_b();
        test_rev_a();
        test_e_at_zero();
        test_simultaneous();
        test_sst_act();
        test_mid_filter_reset();
`ifdef MMC3_IRQ_SST_EN
        test_sst();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
